// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and control-word layout for the P6 pipelined control unit
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  typedef enum logic [1:0] {JMP_PC4 = 2'b00, JMP_BR = 2'b01, JMP_J = 2'b10, JMP_RS = 2'b11} jump_t;
  typedef enum logic [1:0] {WD_ALU = 2'b00, WD_DM = 2'b01, WD_PC8 = 2'b10, WD_HILO = 2'b11} wd_t;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_t;
  typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_BYTE = 2'b01} dm_size_t;

  // ALU_NONE keeps an all-zero control word meaning "no operation"
  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
    ALU_OR   = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_LUI = 4'd7
  } alu_t;

  typedef struct packed {
    wd_t        wd;
    logic [4:0] a3;
    logic       grf_we;
  } w_word_t;

  typedef struct packed {
    logic     dm_we;
    logic     dm_re;
    dm_size_t dm_size;
    w_word_t  w;
  } m_word_t;

  typedef struct packed {
    alu_t       alu;
    logic       alub;
    logic       md_start;
    md_op_t     md_op;
    logic [1:0] hilo_we;
    m_word_t    m;
  } e_word_t;

  // md_use flags the eight ops that must wait for the mult/div unit
  typedef struct packed {
    jump_t   jump;
    logic    ext;
    logic    md_use;
    e_word_t e;
  } ctrl_word_t;

  localparam ctrl_word_t NOP_WORD = '0;
  localparam e_word_t    NOP_E    = '0;
  localparam m_word_t    NOP_M    = '0;
  localparam w_word_t    NOP_W    = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction to control-word decoder for the D stage
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        equal,
  output ctrl_word_t  word
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dest;
  logic       wr;
  logic       unused_fields;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign unused_fields = &{1'b0, instr[25:21], instr[10:6]};

  always_comb begin
    word = NOP_WORD;
    dest = 5'd0;
    wr   = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest = rd;
        case (funct)
          F_ADDU: begin word.e.alu = ALU_ADD;  wr = 1'b1; end
          F_SUBU: begin word.e.alu = ALU_SUB;  wr = 1'b1; end
          F_AND:  begin word.e.alu = ALU_AND;  wr = 1'b1; end
          F_OR:   begin word.e.alu = ALU_OR;   wr = 1'b1; end
          F_SLT:  begin word.e.alu = ALU_SLT;  wr = 1'b1; end
          F_SLTU: begin word.e.alu = ALU_SLTU; wr = 1'b1; end
          F_JR:   word.jump = JMP_RS;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            word.md_use     = 1'b1;
            word.e.md_start = 1'b1;
            word.e.md_op    = md_op_t'(funct[1:0]);
          end
          F_MFHI, F_MFLO: begin
            word.md_use   = 1'b1;
            word.e.m.w.wd = WD_HILO;
            wr            = 1'b1;
          end
          F_MTHI: begin word.md_use = 1'b1; word.e.hilo_we = 2'b10; end
          F_MTLO: begin word.md_use = 1'b1; word.e.hilo_we = 2'b01; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        word.e.alu = ALU_ADD; word.e.alub = 1'b1; word.ext = 1'b1;
        dest = rt; wr = 1'b1;
      end
      OP_ANDI: begin word.e.alu = ALU_AND; word.e.alub = 1'b1; dest = rt; wr = 1'b1; end
      OP_ORI:  begin word.e.alu = ALU_OR;  word.e.alub = 1'b1; dest = rt; wr = 1'b1; end
      OP_LUI:  begin word.e.alu = ALU_LUI; word.e.alub = 1'b1; dest = rt; wr = 1'b1; end
      OP_LW, OP_LB: begin
        word.e.alu = ALU_ADD; word.e.alub = 1'b1; word.ext = 1'b1;
        word.e.m.dm_re   = 1'b1;
        word.e.m.dm_size = (op == OP_LB) ? SZ_BYTE : SZ_WORD;
        word.e.m.w.wd    = WD_DM;
        dest = rt; wr = 1'b1;
      end
      OP_SW, OP_SB: begin
        word.e.alu = ALU_ADD; word.e.alub = 1'b1; word.ext = 1'b1;
        word.e.m.dm_we   = 1'b1;
        word.e.m.dm_size = (op == OP_SB) ? SZ_BYTE : SZ_WORD;
      end
      OP_BEQ: begin word.ext = 1'b1; word.jump = equal ? JMP_BR : JMP_PC4; end
      OP_BNE: begin word.ext = 1'b1; word.jump = equal ? JMP_PC4 : JMP_BR; end
      OP_J:   word.jump = JMP_J;
      OP_JAL: begin
        word.jump     = JMP_J;
        word.e.m.w.wd = WD_PC8;
        dest = 5'd31; wr = 1'b1;
      end
      default: ;
    endcase
    // $0 is never written, so a zero destination collapses to no write at all
    if (wr && (dest != 5'd0)) begin
      word.e.m.w.a3     = dest;
      word.e.m.w.grf_we = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined control unit: D decode, E/M/W control registers, mult/div busy sequencing
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        equal,
  input  logic        larger,
  input  logic        smaller,
  input  logic        stall,
  output logic [1:0]  jump_ctrl_d,
  output logic        ext_ctrl_d,
  output logic [3:0]  alu_ctrl_e,
  output logic        alub_ctrl_e,
  output logic        md_start_e,
  output logic [1:0]  md_op_e,
  output logic [1:0]  hilo_we_e,
  output logic        md_busy,
  output logic        md_stall,
  output logic        dm_we_m,
  output logic        dm_re_m,
  output logic [1:0]  dm_size_m,
  output logic [1:0]  wd_ctrl_w,
  output logic [4:0]  a3_w,
  output logic        grf_we_w
);

  ctrl_word_t       d_word;
  e_word_t          e_q;
  m_word_t          m_q;
  w_word_t          w_q;
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] load_val;
  logic             hold;
  logic             unused_cmp;

  // larger/smaller are reserved for the signed-compare branches not yet decoded
  assign unused_cmp = &{1'b0, larger, smaller};

  ctrl_decode u_decode (
    .instr (instr_d),
    .equal (equal),
    .word  (d_word)
  );

  assign md_busy  = (busy_cnt != '0) || e_q.md_start;
  assign md_stall = d_word.md_use && md_busy;
  assign hold     = stall || md_stall;

  assign jump_ctrl_d = hold ? JMP_PC4 : d_word.jump;
  assign ext_ctrl_d  = d_word.ext;

  assign load_val = e_q.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q      <= NOP_E;
      m_q      <= NOP_M;
      w_q      <= NOP_W;
      busy_cnt <= '0;
    end else begin
      e_q <= hold ? NOP_E : d_word.e;
      m_q <= e_q.m;
      w_q <= m_q.w;
      // a start arriving while already counting is dropped rather than reloading
      if (e_q.md_start && (busy_cnt == '0)) begin
        busy_cnt <= load_val;
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
      end
    end
  end

  assign alu_ctrl_e  = e_q.alu;
  assign alub_ctrl_e = e_q.alub;
  assign md_start_e  = e_q.md_start;
  assign md_op_e     = e_q.md_op;
  assign hilo_we_e   = e_q.hilo_we;
  assign dm_we_m     = m_q.dm_we;
  assign dm_re_m     = m_q.dm_re;
  assign dm_size_m   = m_q.dm_size;
  assign wd_ctrl_w   = w_q.wd;
  assign a3_w        = w_q.a3;
  assign grf_we_w    = w_q.grf_we;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        equal, larger, smaller, stall;
  logic [1:0]  jump_ctrl_d;
  logic        ext_ctrl_d;
  logic [3:0]  alu_ctrl_e;
  logic        alub_ctrl_e, md_start_e;
  logic [1:0]  md_op_e, hilo_we_e;
  logic        md_busy, md_stall, dm_we_m, dm_re_m;
  logic [1:0]  dm_size_m, wd_ctrl_w;
  logic [4:0]  a3_w;
  logic        grf_we_w;

  int total = 0;
  int bad   = 0;

  ctrl_pipe #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .equal(equal), .larger(larger),
    .smaller(smaller), .stall(stall), .jump_ctrl_d(jump_ctrl_d), .ext_ctrl_d(ext_ctrl_d),
    .alu_ctrl_e(alu_ctrl_e), .alub_ctrl_e(alub_ctrl_e), .md_start_e(md_start_e),
    .md_op_e(md_op_e), .hilo_we_e(hilo_we_e), .md_busy(md_busy), .md_stall(md_stall),
    .dm_we_m(dm_we_m), .dm_re_m(dm_re_m), .dm_size_m(dm_size_m), .wd_ctrl_w(wd_ctrl_w),
    .a3_w(a3_w), .grf_we_w(grf_we_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] regs_now();
    return {9'd0, alu_ctrl_e, alub_ctrl_e, md_start_e, md_op_e, hilo_we_e, md_busy,
            dm_we_m, dm_re_m, dm_size_m, wd_ctrl_w, a3_w, grf_we_w};
  endfunction

  initial begin
    reset = 1'b0; instr_d = 32'd0; equal = 1'b0; larger = 1'b0; smaller = 1'b0; stall = 1'b0;
    tick(); tick();
    chk("reset_regs", regs_now(), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_regs", regs_now(), 32'd0);
    chk("post_reset_comb", {29'd0, md_stall, jump_ctrl_d}, 32'd0);

    // addu $3,$1,$2
    instr_d = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    #1 chk("addu_jump", jump_ctrl_d, 32'd0);
    tick(); instr_d = 32'd0;
    chk("addu_e", {alu_ctrl_e, alub_ctrl_e}, {27'd0, 4'd1, 1'b0});
    tick();
    chk("addu_m", {dm_we_m, dm_re_m}, 32'd0);
    tick();
    chk("addu_w", {grf_we_w, a3_w, wd_ctrl_w}, {24'd0, 1'b1, 5'd3, 2'b00});

    // branch selects and the stall override
    instr_d = i_ins(6'h04, 5'd1, 5'd2, 16'h0010); equal = 1'b1;
    #1 chk("beq_eq", jump_ctrl_d, 32'd1);
    chk("beq_ext", ext_ctrl_d, 32'd1);
    equal = 1'b0;
    #1 chk("beq_ne", jump_ctrl_d, 32'd0);
    instr_d = i_ins(6'h05, 5'd1, 5'd2, 16'h0010); equal = 1'b1;
    #1 chk("bne_eq", jump_ctrl_d, 32'd0);
    equal = 1'b0;
    #1 chk("bne_ne", jump_ctrl_d, 32'd1);
    stall = 1'b1;
    #1 chk("bne_stalled", jump_ctrl_d, 32'd0);
    stall = 1'b0;
    instr_d = i_ins(6'h06, 5'd1, 5'd0, 16'h0010);
    #1 chk("blez_nop_jump", jump_ctrl_d, 32'd0);
    instr_d = i_ins(6'h0d, 5'd1, 5'd2, 16'hffff);
    #1 chk("ori_ext", ext_ctrl_d, 32'd0);
    instr_d = r_ins(5'd31, 5'd0, 5'd0, 6'h08);
    #1 chk("jr_jump", jump_ctrl_d, 32'd3);

    // jal writes $31 with PC+8
    instr_d = {6'h03, 26'h0000040};
    #1 chk("jal_jump", jump_ctrl_d, 32'd2);
    tick(); instr_d = 32'd0;
    tick(); tick();
    chk("jal_w", {grf_we_w, a3_w, wd_ctrl_w}, {24'd0, 1'b1, 5'd31, 2'b10});

    // addi to $0 must not write
    instr_d = i_ins(6'h08, 5'd1, 5'd0, 16'h0005);
    tick(); instr_d = 32'd0;
    chk("addi_r0_e", {alu_ctrl_e, alub_ctrl_e}, {27'd0, 4'd1, 1'b1});
    tick(); tick();
    chk("addi_r0_w", {grf_we_w, a3_w}, 32'd0);

    // div in E, mflo $4 waiting in D
    instr_d = r_ins(5'd1, 5'd2, 5'd0, 6'h1a);
    tick();
    instr_d = r_ins(5'd0, 5'd0, 5'd4, 6'h12);
    #1 chk("div_start", {md_start_e, md_op_e}, {29'd0, 1'b1, 2'b10});
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("div_busy_%0d", k), md_busy, 32'd1);
      chk($sformatf("div_stall_%0d", k), md_stall, 32'd1);
      if (k > 0) chk($sformatf("div_e_nop_%0d", k),
                     {alu_ctrl_e, alub_ctrl_e, md_start_e, md_op_e, hilo_we_e}, 32'd0);
      tick();
    end
    chk("div_busy_fall", {md_busy, md_stall}, 32'd0);
    tick(); instr_d = 32'd0;
    tick();
    chk("mflo_not_early", grf_we_w, 32'd0);
    tick();
    chk("mflo_w", {grf_we_w, a3_w, wd_ctrl_w}, {24'd0, 1'b1, 5'd4, 2'b11});

    // mult in E, mthi waiting in D
    instr_d = r_ins(5'd1, 5'd2, 5'd0, 6'h18);
    tick();
    instr_d = r_ins(5'd1, 5'd0, 5'd0, 6'h11);
    #1 chk("mult_start", {md_start_e, md_op_e}, {29'd0, 1'b1, 2'b00});
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("mult_busy_%0d", k), {md_busy, md_stall}, 32'd3);
      chk($sformatf("mult_hilo_%0d", k), hilo_we_e, 32'd0);
      tick();
    end
    chk("mult_busy_fall", {md_busy, md_stall}, 32'd0);
    tick(); instr_d = 32'd0;
    chk("mthi_e", hilo_we_e, 32'd2);

    // sw held by a 3-cycle stall
    instr_d = i_ins(6'h2b, 5'd1, 5'd2, 16'h0004); stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("sw_bubble_e_%0d", k), alub_ctrl_e, 32'd0);
      chk($sformatf("sw_bubble_m_%0d", k), dm_we_m, 32'd0);
    end
    stall = 1'b0;
    tick(); instr_d = 32'd0;
    chk("sw_e", {alu_ctrl_e, alub_ctrl_e}, {27'd0, 4'd1, 1'b1});
    chk("sw_m_before", dm_we_m, 32'd0);
    tick();
    chk("sw_m_pulse", {dm_we_m, dm_size_m}, {29'd0, 1'b1, 2'b00});
    tick();
    chk("sw_m_after", dm_we_m, 32'd0);

    // reset while the busy counter holds 6, pipeline full of lw
    instr_d = r_ins(5'd1, 5'd2, 5'd0, 6'h1a);
    tick();
    instr_d = i_ins(6'h23, 5'd1, 5'd5, 16'h0000);
    for (int k = 0; k < 5; k++) tick();
    chk("pre_reset_busy", md_busy, 32'd1);
    chk("pre_reset_pipe", {alub_ctrl_e, dm_re_m, grf_we_w, a3_w}, {24'd0, 1'b1, 1'b1, 1'b1, 5'd5});
    reset = 1'b0;
    tick();
    chk("mid_reset_regs", regs_now(), 32'd0);
    reset = 1'b1; instr_d = 32'd0;
    tick();
    chk("after_reset_busy", md_busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the P6 CPU; successor to the single-stage combinational signal generator. It decodes the instruction held in D into a control word and carries that word through registered E, M and W stages. It inserts bubbles on stall and sequences a multi-cycle multiply/divide unit with a busy counter. It also raises the multiply/divide stall request consumed by the hazard unit.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu, ≥1.
- DIV_CYCLES, default 10: busy cycles for div/divu, ≥1.
- CNT_W, default 4: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_d  in  32  instruction in D stage.
- equal, larger, smaller  in  1 each  D-stage rs/rt compare results.
- stall  in  1  hazard-unit stall; E receives a bubble.
- jump_ctrl_d  out  2  next-PC select: 00 PC+4, 01 branch target, 10 j target, 11 rs.
- ext_ctrl_d  out  1  0 zero-extend, 1 sign-extend.
- alu_ctrl_e  out  4  ALU op.
- alub_ctrl_e  out  1  0 RD2, 1 EXT.
- md_start_e  out  1  start pulse to the mult/div unit.
- md_op_e  out  2  00 mult, 01 multu, 10 div, 11 divu.
- hilo_we_e  out  2  bit1 HI write (mthi), bit0 LO write (mtlo).
- md_busy  out  1  mult/div unit busy.
- md_stall  out  1  stall request to the hazard unit.
- dm_we_m, dm_re_m  out  1 each  data-memory write and read enables.
- dm_size_m  out  2  00 word, 01 byte.
- wd_ctrl_w  out  2  00 ALU, 01 DM, 10 PC+8, 11 HI/LO.
- a3_w  out  5  destination register; 0 means no write.
- grf_we_w  out  1  register-file write enable.

## Operation
- Supported instructions: addu, subu, and, or, slt, sltu, addi(u), andi, ori, lui, lw, lb, sw, sb, beq, bne, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Unknown opcode or funct decodes to NOP: all enables 0, jump_ctrl 00.
- Decode is combinational in D. It produces a control word plus the destination register: rd for R-type, rt for I-type loads and ALU ops, 31 for jal.
- If the destination is 0, grf_we is forced to 0.
- Branch select: beq → {0,equal}; bne → {0,~equal}. larger and smaller are reserved for blez, bgtz, bltz and bgez; those are decoded to NOP in this revision.
- jump_ctrl_d is forced to 00 while stall or md_stall is high.
- Pipeline registers:
  - E ← decoded word, or NOP when stall or md_stall is high.
  - M ← E.
  - W ← M.
  - Each stage exposes only the fields it consumes.
- Busy counter:
  - When md_start_e=1 and the counter is 0, load MULT_CYCLES or DIV_CYCLES according to md_op_e.
  - Otherwise, if the counter is nonzero, decrement by 1.
- md_busy is 1 when the counter is nonzero or md_start_e=1.
- md_stall is 1 when the D instruction is any of the 8 mult/div/HI/LO ops and md_busy=1.
- md_start_e while the counter is nonzero must not occur; if it does, it is ignored and the counter is not reloaded.

## Timing
- Reset (reset=0 at an edge): E/M/W registers clear to NOP and the counter clears to 0.
- After reset: every registered output is 0, md_busy=0, md_stall=0.
- Reset overrides stall and any counter load.
- Latency: an instruction decoded in D in cycle n drives its E outputs in n+1, M in n+2 and W in n+3.
- Stall held for k cycles inserts k E bubbles; the instruction in D enters E in the cycle after stall falls.
- mult issued into E at cycle t:
  - md_busy is high in cycles t through t+MULT_CYCLES.
  - It falls at t+MULT_CYCLES+1.
  - A waiting mfhi in D is released in that cycle.
- jump_ctrl_d, ext_ctrl_d and md_stall are combinational; all other outputs are registered.

## Structure
- Package ctrl_pkg holds:
  - opcode/funct constants;
  - the jump, wd, alu, md_op and dm_size encodings;
  - a packed ctrl_word_t struct;
  - the NOP constant.
- The natural sub-module is ctrl_decode: the pure combinational instr→ctrl_word_t decoder, instantiated once in D.
- ctrl_pipe holds the stage registers, bubble logic and busy counter.

## Test plan
- Reset held 2 cycles, then released with instr_d=0 → all outputs 0 and md_stall=0.
- addu $3,$1,$2 with no stall:
  - cycle+1: alu_ctrl_e=add, alub=0.
  - cycle+3: grf_we_w=1, a3_w=3, wd_ctrl_w=00.
- beq with equal=1 → jump_ctrl_d=01; bne with equal=1 → 00; jal → a3_w=31 and wd_ctrl_w=10 three cycles later.
- div in E, mflo in D, DIV_CYCLES=10:
  - md_busy high for 11 cycles.
  - md_stall high the whole time, with E holding NOPs.
  - mflo reaches E on the cycle after md_busy falls.
- stall=1 for 3 cycles holding sw → three NOP bubbles in E/M (dm_we_m=0), followed by exactly one dm_we_m=1 pulse.
- reset=0 asserted while the busy counter=6 → counter 0 and md_busy=0 next cycle, and all pipeline registers are NOP.
